// File: rtl/activation_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : activation_scheduler
// Brief    : Round-robin sharing of one ReLU stage among NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
module activation_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int LANES   = 10,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*LANES*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]               req_bypass,
    output logic [LANES*DATA_W-1:0]          act_in,
    output logic                             act_hold,
    input  logic [LANES*DATA_W-1:0]          act_out,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [LANES*DATA_W-1:0]          rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [CNT_W-1:0]                 vec_count
);

    localparam int c_idw = $clog2(NUM_REQ);
    localparam int c_vw  = LANES * DATA_W;
    localparam logic [c_idw:0] c_num = (c_idw + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_idw-1:0]    r_last;
    logic [c_idw-1:0]    r_id;
    logic                r_byp;
    logic [c_idw-1:0]    w_win;
    logic [c_idw:0]      w_sum;
    logic [NUM_REQ-1:0]  w_rot;
    logic                w_found;
    logic                w_window;
    logic                w_xfer;
    logic [c_vw-1:0]     w_sel_data;
    logic                w_sel_byp;

    assign w_window = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);

    // Bit j of w_rot is requester (last+1+j) mod NUM_REQ, so the lowest set bit wins.
    assign w_rot = NUM_REQ'({req_valid, req_valid} >> ({1'b0, r_last} + (c_idw + 1)'(1)));

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_last} + (c_idw + 1)'(j + 1);
            end
        end
        if (w_sum >= c_num) begin
            w_sum = w_sum - c_num;
        end
        w_win = w_sum[c_idw-1:0];
    end

    assign w_xfer    = w_window && w_found;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        w_sel_data = '0;
        w_sel_byp  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_win == c_idw'(r)) begin
                w_sel_data = req_data[r*c_vw +: c_vw];
                w_sel_byp  = req_bypass[r];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) w_state_nxt = w_xfer ? ST_ISSUE : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign act_hold = (r_state != ST_ISSUE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_last    <= c_idw'(NUM_REQ - 1);
            r_id      <= '0;
            r_byp     <= 1'b0;
            act_in    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            vec_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                act_in <= w_sel_data;
                r_byp  <= w_sel_byp;
                r_id   <= w_win;
                r_last <= w_win;
            end
            if (r_state == ST_ISSUE) begin
                rsp_data  <= r_byp ? act_in : act_out;
                rsp_id    <= r_id;
                rsp_valid <= 1'b1;
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                if (vec_count != {CNT_W{1'b1}}) begin
                    vec_count <= vec_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
